// File: rtl/arty_led_pkg.sv
// arty_led_pkg: shared mode/scan enums, first colour and the colour stepping helper for arty_led_sequencer.
package arty_led_pkg;
  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_ALL_ON  = 2'd3
  } mode_t;
  typedef enum logic {
    SCAN_UP   = 1'b0,
    SCAN_DOWN = 1'b1
  } scan_state_t;
  localparam logic [2:0] COLOR_FIRST = 3'b001;
  // Off (000) is never a colour: 111 wraps straight back to 001.
  function automatic logic [2:0] next_color(input logic [2:0] c);
    return c == 3'b111 ? COLOR_FIRST : c + 3'd1;
  endfunction
endpackage

// File: rtl/led_step_prescaler.sv
// led_step_prescaler: counts 0..STEP_CLKS-1 while not paused; step is high on the wrap cycle.
module led_step_prescaler #(
  parameter int STEP_CLKS = 32500000
) (
  input  logic clk,
  input  logic rst,
  input  logic pause,
  output logic step
);
  localparam int W = STEP_CLKS > 1 ? $clog2(STEP_CLKS) : 1;
  logic [W-1:0] cnt;
  assign step = !pause && cnt == W'(STEP_CLKS - 1);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (!pause) cnt <= step ? '0 : cnt + 1'b1;
endmodule

// File: rtl/arty_led_sequencer.sv
// arty_led_sequencer: N-LED count/scan/breathe/all-on pattern generator with RGB colour cycling and PWM gating.
// BREATHE mode exists only when ARTY_LED_BREATHE_EN is defined; otherwise mode 2 behaves as COUNT.
module arty_led_sequencer
  import arty_led_pkg::*;
#(
  parameter int NUM_LEDS  = 4,
  parameter int STEP_CLKS = 32500000,
  parameter int PWM_BITS  = 3,
  parameter int RGB_DUTY  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  pause,
  output logic [NUM_LEDS-1:0]   led_g,
  output logic [3*NUM_LEDS-1:0] led_rgb,
  output logic                  step_pulse
);
  localparam int PW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
  logic step, adv, g_gate, rgb_gate;
  mode_t mode_q, nxt_mode, req;
  scan_state_t dir, nxt_dir;
  logic [NUM_LEDS-1:0] cnt, nxt_cnt, pat;
  logic [PW-1:0] pos, nxt_pos;
  logic [2:0] color, nxt_color;
  logic [PWM_BITS-1:0] pwm;
  logic [3*NUM_LEDS-1:0] rgb;
  led_step_prescaler #(.STEP_CLKS(STEP_CLKS)) u_pre (
    .clk(clk), .rst(rst), .pause(pause), .step(step)
  );
`ifdef ARTY_LED_BREATHE_EN
  logic [PWM_BITS-1:0] level, nxt_level;
  assign req = mode_t'(mode);
  always_ff @(posedge clk) level <= rst ? '0 : nxt_level;
`else
  assign req = mode == 2'd2 ? MODE_COUNT : mode_t'(mode);
`endif
  // dir doubles as the BREATHE ramp direction, so a mode change clears both in one place.
  always_comb begin
    nxt_mode = mode_q;
    nxt_dir = dir;
    nxt_cnt = cnt;
    nxt_pos = pos;
`ifdef ARTY_LED_BREATHE_EN
    nxt_level = level;
`endif
    adv = 1'b0;
    if (step && req != mode_q) begin
      nxt_mode = req;
      nxt_dir = SCAN_UP;
      nxt_cnt = '0;
      nxt_pos = '0;
`ifdef ARTY_LED_BREATHE_EN
      nxt_level = '0;
`endif
    end else if (step) begin
      case (mode_q)
        MODE_COUNT: begin
          nxt_cnt = cnt + 1'b1;
          adv = &cnt;
        end
        MODE_SCAN:
          if (NUM_LEDS == 1) adv = 1'b1;
          else if (dir == SCAN_UP) begin
            nxt_pos = pos + 1'b1;
            nxt_dir = int'(pos) == NUM_LEDS - 2 ? SCAN_DOWN : SCAN_UP;
          end else begin
            nxt_pos = pos - 1'b1;
            nxt_dir = pos == PW'(1) ? SCAN_UP : SCAN_DOWN;
            adv = pos == PW'(1);
          end
`ifdef ARTY_LED_BREATHE_EN
        MODE_BREATHE:
          if (dir == SCAN_UP) begin
            nxt_level = level + 1'b1;
            nxt_dir = &nxt_level ? SCAN_DOWN : SCAN_UP;
          end else begin
            nxt_level = level - 1'b1;
            nxt_dir = level == PWM_BITS'(1) ? SCAN_UP : SCAN_DOWN;
            adv = level == PWM_BITS'(1);
          end
`endif
        default: adv = 1'b1;
      endcase
    end
    nxt_color = adv ? next_color(color) : color;
    pat = nxt_mode == MODE_COUNT ? nxt_cnt : nxt_mode == MODE_SCAN ? NUM_LEDS'(1) << nxt_pos : '1;
`ifdef ARTY_LED_BREATHE_EN
    g_gate = nxt_mode == MODE_BREATHE ? pwm < nxt_level : 1'b1;
    rgb_gate = nxt_mode == MODE_BREATHE ? pwm < nxt_level : {1'b0, pwm} < (PWM_BITS + 1)'(RGB_DUTY);
`else
    g_gate = 1'b1;
    rgb_gate = {1'b0, pwm} < (PWM_BITS + 1)'(RGB_DUTY);
`endif
    rgb = '0;
    for (int i = 0; i < NUM_LEDS; i++) rgb[3*i +: 3] = pat[i] ? nxt_color & {3{rgb_gate}} : 3'b000;
  end
  always_ff @(posedge clk)
    if (rst) begin
      mode_q <= MODE_COUNT;
      dir <= SCAN_UP;
      cnt <= '0;
      pos <= '0;
      color <= COLOR_FIRST;
      pwm <= '0;
      led_g <= '0;
      led_rgb <= '0;
      step_pulse <= 1'b0;
    end else begin
      mode_q <= nxt_mode;
      dir <= nxt_dir;
      cnt <= nxt_cnt;
      pos <= nxt_pos;
      color <= nxt_color;
      pwm <= pwm + 1'b1;
      led_g <= pat & {NUM_LEDS{g_gate}};
      led_rgb <= rgb;
      step_pulse <= step;
    end
endmodule

// File: doc/arty_led_sequencer.md
# arty_led_sequencer

Parametrised LED pattern generator driving the Arty Green and RGB LED banks from one clock. It generalises the fixed 4-LED binary-count blinky to N LEDs and runtime-selectable modes: binary count, bouncing scan, breathing, and all-on. Per-LED RGB colour sequencing and PWM dimming are included. It sits at the top level between the global-buffered clock and the LED pins.

## Interface
- `NUM_LEDS`, 4: number of Green LEDs and RGB LEDs (≥1).
- `STEP_CLKS`, 32500000: clocks per pattern step (≥1); 0.5 s at 65 MHz.
- `PWM_BITS`, 3: PWM counter width (1..8).
- `RGB_DUTY`, 1: RGB on-slots per PWM period (0..2^PWM_BITS).
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mode` in 2: 0 COUNT, 1 SCAN, 2 BREATHE, 3 ALL_ON.
- `pause` in 1: freezes the prescaler and the pattern. PWM keeps running.
- `led_g` out NUM_LEDS: Green LEDs, active-high.
- `led_rgb` out 3*NUM_LEDS: LED i occupies bits [3i+2:3i] = {blue,green,red}.
- `step_pulse` out 1: one-cycle strobe per pattern step.

## Operation
- **Reset values.** All outputs are 0. Prescaler is 0, step counter is 0, scan state is SCAN_UP, colour is 3'b001, level is 0, and the latched mode is COUNT.
- **Prescaler.** Counts 0..STEP_CLKS-1 while `pause`=0 and holds while `pause`=1. The wrap cycle is the "step". `step_pulse` is registered and goes high for the cycle after the wrap. With STEP_CLKS=1, every non-paused cycle is a step.
- **Mode latch.** `mode` is sampled only on a step.
  - If the sampled value differs from the latched mode, the new mode is latched and the step counter, scan state and level are cleared to their reset values.
  - Colour is kept across a mode change.
  - No pattern advance happens on a mode-change step.
- **PWM counter.** PWM_BITS wide, increments every clock, wraps naturally, ignores `pause`. Cleared only by `rst`.
- **COUNT mode.** The pattern is the step counter (NUM_LEDS bits, +1 per step). When it wraps from all-ones to 0, colour advances.
- **SCAN mode.** The pattern is one-hot at position p.
  - In SCAN_UP, p increments. At p=NUM_LEDS-1 the state becomes SCAN_DOWN on the same step.
  - In SCAN_DOWN, p decrements. At p=0 the state becomes SCAN_UP and colour advances.
  - With NUM_LEDS=1, p stays 0 and colour advances every step.
- **BREATHE mode.** The pattern is all-ones and the level ramps 0→2^PWM_BITS-1→0.
  - Level rises by 1 per step up to the max, then falls by 1 per step.
  - Colour advances when the level returns to 0.
- **ALL_ON mode.** The pattern is all-ones and colour advances every step.
- **Colour sequence.** 001→010→…→111→001. The value 000 is never produced.
- **Gating.** `led_g[i]` = pattern[i] & g_gate, and `led_rgb[i]` = pattern[i] ? colour & {3{rgb_gate}} : 0.
  - In BREATHE: g_gate = rgb_gate = (pwm_cnt < level).
  - In all other modes: g_gate = 1 and rgb_gate = (pwm_cnt < RGB_DUTY).
  - RGB_DUTY=0 keeps the RGB LEDs dark. RGB_DUTY=2^PWM_BITS keeps them fully on.
- **Pause.** A step is suppressed when the prescaler's wrap cycle coincides with `pause`=1. The pattern, colour and level hold their values. Outputs continue to be PWM-gated.

## Timing
- All outputs are registered. Any change in pattern, colour or PWM state appears on the outputs exactly 1 cycle later.
- **Pattern update.** The pattern updates on the step cycle and is visible on the LEDs on the next cycle, which is the same cycle `step_pulse` is high.
- **Mode change.** The earliest effect is 1 cycle after the first step at which the new `mode` value is sampled.
- **`rst` mid-operation.** Outputs are 0 in the cycle after `rst` is sampled high, regardless of mode. The first step occurs STEP_CLKS cycles after `rst` deasserts.

## Configuration
- `ARTY_LED_BREATHE_EN` defined: BREATHE mode is implemented as above.
- `ARTY_LED_BREATHE_EN` undefined:
  - The level register and ramp logic are removed.
  - `mode`=2 is treated as COUNT, both at the latch and in decoding.
  - A 2→0 change does not count as a mode change.

## Structure
- Package `arty_led_pkg` holds:
  - `mode_t` enum (MODE_COUNT, MODE_SCAN, MODE_BREATHE, MODE_ALL_ON);
  - `scan_state_t` (SCAN_UP, SCAN_DOWN);
  - `COLOR_FIRST` = 3'b001;
  - a `next_color()` function implementing the 000-skipping wrap.
- Sub-module `led_step_prescaler`: the prescaler with `pause` input and `step` output, parameter STEP_CLKS, with the counter width from $clog2 and a minimum width of 1.

## Test plan
- **Reset / first step.** NUM_LEDS=4, STEP_CLKS=4, mode=0. Release `rst` → outputs are 0 through the first step. On the first `step_pulse`, `led_g`=4'b0001.
- **COUNT wrap.** Run 16 steps → `led_g` goes 1..15 then 0. `led_rgb` colour changes from 001 to 010 at the 0 pattern. With RGB_DUTY=1 and PWM_BITS=3, `led_rgb` is nonzero on exactly 1 of every 8 cycles.
- **SCAN bounce.** mode=1, NUM_LEDS=4 → `led_g` sequence 0001,0010,0100,1000,0100,0010,0001,0010. Colour advances once, at the return to 0001.
- **BREATHE.** PWM_BITS=2 → level sequence 0,1,2,3,2,1,0. At level 3, `led_g` is 4'hF on 3 of every 4 cycles. At level 0, it is all-off.
- **Pause / mode change.**
  - Hold `pause` for 10 steps → no `step_pulse`, `led_g` unchanged.
  - Switch mode 0→3 mid-interval → the change takes effect only after the next step, and colour is preserved.
- **Macro off.** Without `ARTY_LED_BREATHE_EN`, mode=2 gives the same `led_g` sequence as mode=0.
